// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit feeding the HI/LO write ports.
// Define MDU_MADD_EN to turn ops 1xx into MADD/MSUB accumulates; otherwise they act as MULT/MULTU.
module mdu_unit #(
    parameter int DIV_ITERS = 32
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start_valid,
    output logic        start_ready,
    input  logic [2:0]  op,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    input  logic [31:0] hi_in,
    input  logic [31:0] lo_in,
    input  logic        cancel,
    output logic        busy,
    output logic        we_hi,
    output logic        we_lo,
    output logic [31:0] wdata_hi,
    output logic [31:0] wdata_lo
);

    localparam int CW = $clog2(DIV_ITERS);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t state, state_next;

    logic          accept;
    logic          is_div_op;
    logic          sgn_q;
    logic [31:0]   a_q, b_q;
    logic [31:0]   quo_q, rem_q, dvsr_q;
    logic [CW-1:0] cnt_q;
    logic          last_iter;
    logic [31:0]   mag1, mag2;

    logic [63:0]   a_ext, b_ext, product, mul_result;
    logic [32:0]   shifted, diff;
    logic          fits;
    logic [31:0]   quo_step, rem_step, quo_fix, rem_fix;

`ifdef MDU_MADD_EN
    logic          acc_q, sub_q;
    logic [31:0]   acc_hi_q, acc_lo_q;
`else
    logic          unused_acc;
    assign unused_acc = ^{hi_in, lo_in};
`endif

    assign accept      = start_valid & start_ready & ~cancel;
    assign is_div_op   = (op[2:1] == 2'b01);
    assign last_iter   = (cnt_q == CW'(DIV_ITERS - 1));
    assign start_ready = (state == IDLE);
    assign busy        = (state != IDLE);
    // A flush landing in DONE must still kill the write, so the pulse is gated by cancel.
    assign we_hi       = (state == DONE) & ~cancel;
    assign we_lo       = (state == DONE) & ~cancel;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = is_div_op ? DIV : MUL;
            MUL:     state_next = DONE;
            DIV:     if (last_iter) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (cancel) state_next = IDLE;
    end

    always_comb begin
        mag1    = (~op[0] & src1[31]) ? -src1 : src1;
        mag2    = (~op[0] & src2[31]) ? -src2 : src2;
        a_ext   = sgn_q ? {{32{a_q[31]}}, a_q} : {32'b0, a_q};
        b_ext   = sgn_q ? {{32{b_q[31]}}, b_q} : {32'b0, b_q};
        product = a_ext * b_ext;
`ifdef MDU_MADD_EN
        if (acc_q) mul_result = sub_q ? ({acc_hi_q, acc_lo_q} - product)
                                      : ({acc_hi_q, acc_lo_q} + product);
        else       mul_result = product;
`else
        mul_result = product;
`endif
        // Restoring step: shift the next dividend bit into the partial remainder and try to subtract.
        shifted  = {rem_q, quo_q[31]};
        fits     = (shifted >= {1'b0, dvsr_q});
        diff     = shifted - {1'b0, dvsr_q};
        rem_step = fits ? diff[31:0] : shifted[31:0];
        quo_step = {quo_q[30:0], fits};
        quo_fix  = (sgn_q & (a_q[31] ^ b_q[31])) ? -quo_step : quo_step;
        rem_fix  = (sgn_q & a_q[31]) ? -rem_step : rem_step;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sgn_q    <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            dvsr_q   <= '0;
            cnt_q    <= '0;
            wdata_hi <= '0;
            wdata_lo <= '0;
`ifdef MDU_MADD_EN
            acc_q    <= 1'b0;
            sub_q    <= 1'b0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
`endif
        end else if (accept) begin
            sgn_q    <= ~op[0];
            a_q      <= src1;
            b_q      <= src2;
            quo_q    <= mag1;
            rem_q    <= '0;
            dvsr_q   <= mag2;
            cnt_q    <= '0;
`ifdef MDU_MADD_EN
            acc_q    <= op[2];
            sub_q    <= op[1];
            acc_hi_q <= hi_in;
            acc_lo_q <= lo_in;
`endif
        end else if (!cancel) begin
            if (state == MUL) begin
                wdata_hi <= mul_result[63:32];
                wdata_lo <= mul_result[31:0];
            end
            if (state == DIV) begin
                quo_q <= quo_step;
                rem_q <= rem_step;
                cnt_q <= cnt_q + CW'(1);
                if (last_iter) begin
                    if (b_q == 32'b0) begin
                        wdata_hi <= a_q;
                        wdata_lo <= 32'hFFFF_FFFF;
                    end else begin
                        wdata_hi <= rem_fix;
                        wdata_lo <= quo_fix;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mdu_unit.sv
// Self-checking bench for mdu_unit: directed cases plus randomized ops against an arithmetic model.
module tb_mdu_unit;

    logic        clk;
    logic        resetn;
    logic        start_valid;
    logic        start_ready;
    logic [2:0]  op;
    logic [31:0] src1, src2, hi_in, lo_in;
    logic        cancel;
    logic        busy;
    logic        we_hi, we_lo;
    logic [31:0] wdata_hi, wdata_lo;

    int testsRun;
    int testsFailed;

    mdu_unit dut (
        .clk(clk),
        .resetn(resetn),
        .start_valid(start_valid),
        .start_ready(start_ready),
        .op(op),
        .src1(src1),
        .src2(src2),
        .hi_in(hi_in),
        .lo_in(lo_in),
        .cancel(cancel),
        .busy(busy),
        .we_hi(we_hi),
        .we_lo(we_lo),
        .wdata_hi(wdata_hi),
        .wdata_lo(wdata_lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Arithmetic reference: returns {HI, LO} straight from the operation's definition.
    function automatic logic [63:0] refModel(input logic [2:0] o, input logic [31:0] s1, input logic [31:0] s2,
                                             input logic [31:0] h, input logic [31:0] l);
        longint a, b, q, r;
        logic [63:0] p;
        a = o[0] ? longint'(s1) : longint'($signed(s1));
        b = o[0] ? longint'(s2) : longint'($signed(s2));
        if (o[2:1] == 2'b01) begin
            if (s2 == 32'b0) return {s1, 32'hFFFF_FFFF};
            q = a / b;
            r = a % b;
            return {r[31:0], q[31:0]};
        end
        p = 64'(a * b);
`ifdef MDU_MADD_EN
        if (o[2]) p = o[1] ? ({h, l} - p) : ({h, l} + p);
`endif
        return p;
    endfunction

    task automatic applyStimulus(input logic [2:0] opIn, input logic [31:0] s1, input logic [31:0] s2,
                                 input logic [31:0] h, input logic [31:0] l,
                                 input logic [31:0] expHi, input logic [31:0] expLo);
        int lat;
        int k;
        bit statusOk;
        lat = (opIn[2:1] == 2'b01) ? 33 : 2;
        op = opIn; src1 = s1; src2 = s2; hi_in = h; lo_in = l;
        start_valid = 1'b1;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        op = 3'($urandom); src1 = $urandom; src2 = $urandom; hi_in = $urandom; lo_in = $urandom;
        statusOk = 1'b1;
        k = 0;
        while (k < lat + 5) begin
            @(negedge clk);
            k++;
            if (busy !== 1'b1 || start_ready !== 1'b0) statusOk = 1'b0;
            if (we_hi === 1'b1) break;
            start_valid = (k < lat - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        start_valid = 1'b0;
        checkOutput("latency", 64'(k), 64'(lat));
        checkOutput("busyDuring", {63'b0, statusOk}, 64'd1);
        checkOutput("weLo", {63'b0, we_lo}, 64'd1);
        checkOutput("wdataHi", {32'b0, wdata_hi}, {32'b0, expHi});
        checkOutput("wdataLo", {32'b0, wdata_lo}, {32'b0, expLo});
        @(negedge clk);
        checkOutput("weAfter", {62'b0, we_hi, we_lo}, 64'd0);
        checkOutput("idleAfter", {62'b0, busy, start_ready}, 64'd1);
        checkOutput("hiHeld", {32'b0, wdata_hi}, {32'b0, expHi});
    endtask

    initial begin
        logic [63:0] exp;
        logic [2:0]  o;
        logic [31:0] s1, s2, h, l;
        bit sawWe;

        testsRun = 0;
        testsFailed = 0;
        resetn = 1'b0; start_valid = 1'b0; cancel = 1'b0;
        op = '0; src1 = '0; src2 = '0; hi_in = '0; lo_in = '0;
        #3;
        checkOutput("resetWe", {62'b0, we_hi, we_lo}, 64'd0);
        checkOutput("resetData", {wdata_hi, wdata_lo}, 64'd0);
        checkOutput("resetStatus", {62'b0, busy, start_ready}, 64'd1);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        applyStimulus(3'b000, 32'hFFFF_FFFD, 32'd5, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        applyStimulus(3'b001, 32'hFFFF_FFFD, 32'd5, 32'd0, 32'd0, 32'h0000_0004, 32'hFFFF_FFF1);
        applyStimulus(3'b011, 32'd100, 32'd7, 32'd0, 32'd0, 32'd2, 32'd14);
        applyStimulus(3'b010, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        applyStimulus(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 32'h8000_0000);
        applyStimulus(3'b011, 32'd9, 32'd0, 32'd0, 32'd0, 32'd9, 32'hFFFF_FFFF);
        applyStimulus(3'b010, 32'hFFFF_FFF0, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFF0, 32'hFFFF_FFFF);
`ifdef MDU_MADD_EN
        applyStimulus(3'b101, 32'd1, 32'd1, 32'd0, 32'hFFFF_FFFF, 32'd1, 32'd0);
        applyStimulus(3'b110, 32'd1, 32'd1, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
`else
        applyStimulus(3'b101, 32'd1, 32'd1, 32'd0, 32'hFFFF_FFFF, 32'd0, 32'd1);
        applyStimulus(3'b110, 32'd1, 32'd1, 32'd0, 32'd0, 32'd0, 32'd1);
`endif

        // Cancel a divide in cycle T+10, then launch a MULT right away.
        op = 3'b010; src1 = 32'd1000; src2 = 32'd3; start_valid = 1'b1;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        sawWe = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (we_hi === 1'b1 || we_lo === 1'b1) sawWe = 1'b1;
            if (k == 10) cancel = 1'b1;
        end
        #1;
        if (we_hi === 1'b1 || we_lo === 1'b1) sawWe = 1'b1;
        @(negedge clk);
        checkOutput("cancelStatus", {62'b0, busy, start_ready}, 64'd1);
        checkOutput("cancelNoWe", {63'b0, sawWe}, 64'd0);
        cancel = 1'b0;
        applyStimulus(3'b000, 32'd7, 32'hFFFF_FFFA, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFD6);

        // Cancel landing in DONE must suppress the write pulse.
        op = 3'b001; src1 = 32'd3; src2 = 32'd3; start_valid = 1'b1;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        cancel = 1'b1;
        #1;
        checkOutput("cancelDoneWe", {62'b0, we_hi, we_lo}, 64'd0);
        @(negedge clk);
        checkOutput("cancelDoneIdle", {62'b0, busy, start_ready}, 64'd1);

        // A request coincident with cancel is dropped.
        start_valid = 1'b1; op = 3'b000;
        @(negedge clk);
        checkOutput("startWithCancel", {63'b0, busy}, 64'd0);
        start_valid = 1'b0;
        cancel = 1'b0;

        // Asynchronous reset in the middle of a divide.
        op = 3'b011; src1 = 32'd12345; src2 = 32'd11; start_valid = 1'b1;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        repeat (15) @(negedge clk);
        #2;
        resetn = 1'b0;
        #1;
        checkOutput("asyncResetWe", {62'b0, we_hi, we_lo}, 64'd0);
        checkOutput("asyncResetData", {wdata_hi, wdata_lo}, 64'd0);
        checkOutput("asyncResetStatus", {62'b0, busy, start_ready}, 64'd1);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        applyStimulus(3'b011, 32'd100, 32'd7, 32'd0, 32'd0, 32'd2, 32'd14);

        for (int i = 0; i < 150; i++) begin
            o  = 3'($urandom_range(0, 7));
            s1 = $urandom;
            s2 = $urandom;
            h  = $urandom;
            l  = $urandom;
            if ($urandom_range(0, 3) == 0) s2 = 32'($urandom_range(0, 15));
            if ($urandom_range(0, 9) == 0) s2 = 32'd0;
            if ($urandom_range(0, 9) == 0) s1 = 32'($urandom_range(0, 200));
            exp = refModel(o, s1, s2, h, l);
            applyStimulus(o, s1, s2, h, l, exp[63:32], exp[31:0]);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- Multiply/divide unit in the EX stage; the upstream producer of the HI/LO register file's write ports.
- Accepts one MULT/MULTU/DIV/DIVU (optionally MADD/MSUB family) operation per handshake and runs it over multiple cycles.
- Produces a one-cycle write pulse carrying the HI and LO results, which connects directly to the HI/LO write ports.
- Supports pipeline flush through a cancel input.

Parameters:
- DIV_ITERS, 32, number of divider iterations (one quotient bit per cycle); fixed at 32 for a 32-bit datapath.

Ports:
- clk  input  1  system clock, rising edge
- resetn  input  1  asynchronous active-low reset
- start_valid  input  1  operation request
- start_ready  output  1  unit can accept a request (high only in IDLE)
- op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MADD, 101 MADDU, 110 MSUB, 111 MSUBU
- src1  input  32  rs operand (multiplicand / dividend)
- src2  input  32  rt operand (multiplier / divisor)
- hi_in  input  32  current HI, used by the accumulate ops
- lo_in  input  32  current LO, used by the accumulate ops
- cancel  input  1  flush; aborts the in-flight operation
- busy  output  1  operation in flight (state != IDLE)
- we_hi  output  1  HI write pulse
- we_lo  output  1  LO write pulse
- wdata_hi  output  32  HI result
- wdata_lo  output  32  LO result

Behaviour:
- Reset (resetn low, asynchronous): state=IDLE; we_hi=we_lo=0; wdata_hi=wdata_lo=0; busy=0; start_ready=1; all internal registers cleared.
- Accept: start_valid & start_ready & ~cancel at a rising edge latches op, src1, src2, hi_in and lo_in. Cycle of acceptance = T.
- States:
  - IDLE: on accept of a multiply op go to MUL; on accept of a divide op go to DIV.
  - MUL: one cycle; the 64-bit product is registered (signed when op[0]=0), then go to DONE.
  - DIV: iterative restoring division on operand magnitudes, one bit per cycle, DIV_ITERS cycles. Signs are fixed up on exit into DONE.
  - DONE: one cycle; we_hi=we_lo=1 with valid wdata; next state is IDLE.
- Latency:
  - Multiply: we pulse in cycle T+2.
  - Divide: we pulse in cycle T+DIV_ITERS+1 (T+33).
  - Next request can be accepted in the cycle after DONE.
- Write signals: we_hi and we_lo are registered and high only in DONE. wdata_hi/wdata_lo hold their last values between operations.
- Multiply results: HI=product[63:32], LO=product[31:0].
- Divide results: LO=quotient, HI=remainder.
- Divide sign rules (DIV): quotient is negative iff the operand signs differ; the remainder takes the sign of the dividend. DIVU treats both operands as unsigned.
- Divide by zero (DIV and DIVU): full latency; LO=32'hFFFFFFFF, HI=src1.
- Overflow (DIV 32'h80000000 / 32'hFFFFFFFF): LO=32'h80000000, HI=0.
- Cancel:
  - Asserted in any state other than IDLE: the unit returns to IDLE on the next edge and no we pulse is issued.
  - Cancel asserted during DONE suppresses that cycle's we.
  - A start_valid coincident with cancel is not accepted.
- start_valid asserted while busy is ignored (no queueing).
- src1, src2, hi_in and lo_in may change after acceptance without affecting the result.

Optional Feature:
- MDU_MADD_EN defined:
  - Ops 1xx accumulate: result = {hi_in,lo_in} ± product.
  - The addition or subtraction is performed in the MUL cycle, modulo 2^64. Latency stays T+2.
  - Signedness follows op[0].
- MDU_MADD_EN not defined:
  - hi_in and lo_in are ignored.
  - Ops 1xx execute as plain MULT/MULTU (signedness from op[0]) with no accumulation.

Test Plan:
- MULT src1=32'hFFFFFFFD (-3), src2=5 -> we pulse at T+2 with HI=32'hFFFFFFFF, LO=32'hFFFFFFF1. MULTU with the same operands -> HI=32'h00000004, LO=32'hFFFFFFF1.
- DIVU 100/7 -> we at T+33 with LO=14, HI=2. DIV -7/2 -> LO=32'hFFFFFFFD, HI=32'hFFFFFFFF. Check start_ready=0 and busy=1 for cycles T+1..T+33.
- DIV 32'h80000000 / 32'hFFFFFFFF -> LO=32'h80000000, HI=0. DIVU 9/0 -> LO=32'hFFFFFFFF, HI=9.
- Start DIV, assert cancel at T+10 -> no we pulse, busy=0 and start_ready=1 at T+11. A MULT accepted at T+11 completes correctly at T+13.
- Assert resetn low asynchronously mid-divide -> outputs immediately 0 and busy=0. After release, DIVU 100/7 gives LO=14, HI=2.
- With MDU_MADD_EN: MADDU hi_in=0, lo_in=32'hFFFFFFFF, 1*1 -> HI=1, LO=0. MSUB with {0,0}, 1*1 -> HI=LO=32'hFFFFFFFF. Without the macro, the same MADDU gives HI=0, LO=1.
